// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: fetch-stage address map, exception code and next-PC source encoding
package fetch_pc_unit_pkg;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_REQ,
    SEL_ERET,
    SEL_JR,
    SEL_JUMP,
    SEL_BR,
    SEL_SEQ
  } npc_sel_e;
  function automatic logic adel(input logic [31:0] pc);
    return pc[1:0] != 2'b00 || pc < IM_BASE || pc > IM_LIMIT;
  endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: redirect/exception inputs and fetch outputs of the IF stage
interface fetch_pc_unit_if;
  logic        stall_i;
  logic        req_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [31:0] d_pc_i;
  logic        br_taken_i;
  logic [15:0] br_imm_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        d_is_bj_i;
  logic [31:0] pc_o;
  logic        if_bd_o;
  logic        if_exc_o;
  logic [4:0]  if_exccode_o;
  logic [31:0] fetch_cnt_o;
  modport master (
    output stall_i, req_i, eret_i, epc_i, d_pc_i, br_taken_i, br_imm_i,
           jump_i, jump_target_i, jr_i, jr_target_i, d_is_bj_i,
    input  pc_o, if_bd_o, if_exc_o, if_exccode_o, fetch_cnt_o
  );
  modport slave (
    input  stall_i, req_i, eret_i, epc_i, d_pc_i, br_taken_i, br_imm_i,
           jump_i, jump_target_i, jr_i, jr_target_i, d_is_bj_i,
    output pc_o, if_bd_o, if_exc_o, if_exccode_o, fetch_cnt_o
  );
endinterface

// File: rtl/fetch_pc_unit_npc_select.sv
// fetch_pc_unit_npc_select: prioritised next-PC mux with the branch-target adder
module fetch_pc_unit_npc_select
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] d_pc,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic        advance
);
  npc_sel_e    sel;
  logic [31:0] br_target;
  always_comb begin
    sel = req ? SEL_REQ : eret ? SEL_ERET : stall ? SEL_HOLD : jr ? SEL_JR :
          jump ? SEL_JUMP : br_taken ? SEL_BR : SEL_SEQ;
    br_target = d_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    npc = sel == SEL_REQ  ? HANDLER_PC :
          sel == SEL_ERET ? epc :
          sel == SEL_HOLD ? pc :
          sel == SEL_JR   ? jr_target :
          sel == SEL_JUMP ? jump_target :
          sel == SEL_BR   ? br_target : pc + 32'd4;
    advance = sel != SEL_HOLD;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC register, fetch counter and fetch address-error detection
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
(
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);
  logic [31:0] pc;
  logic [31:0] fetch_cnt;
  logic [31:0] npc;
  logic        advance;
  logic        exc;
  fetch_pc_unit_npc_select u_npc (
    .pc          (pc),
    .stall       (bus.stall_i),
    .req         (bus.req_i),
    .eret        (bus.eret_i),
    .epc         (bus.epc_i),
    .d_pc        (bus.d_pc_i),
    .br_taken    (bus.br_taken_i),
    .br_imm      (bus.br_imm_i),
    .jump        (bus.jump_i),
    .jump_target (bus.jump_target_i),
    .jr          (bus.jr_i),
    .jr_target   (bus.jr_target_i),
    .npc         (npc),
    .advance     (advance)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else if (advance) begin
      pc        <= npc;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
  always_comb begin
    exc              = adel(pc);
    bus.pc_o         = pc;
    bus.fetch_cnt_o  = fetch_cnt;
    bus.if_exc_o     = exc;
    bus.if_exccode_o = exc ? EXC_ADEL : 5'd0;
    bus.if_bd_o      = bus.d_is_bj_i & ~exc;
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and randomized check of fetch_pc_unit against a behavioural PC model
module tb_fetch_pc_unit;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   preload_req = 0;
  int   preload_seen = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  fetch_pc_unit_if ifc ();
  fetch_pc_unit dut (.clk(clk), .reset(reset), .bus(ifc));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    ifc.stall_i = 0; ifc.req_i = 0; ifc.eret_i = 0; ifc.br_taken_i = 0;
    ifc.jump_i = 0; ifc.jr_i = 0; ifc.d_is_bj_i = 0;
  endtask
  initial begin
    logic exp_exc;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pc = 32'h3000;
        m_cnt = 0;
      end else if (ifc.req_i) begin
        m_pc = 32'h4180; m_cnt++;
      end else if (ifc.eret_i) begin
        m_pc = ifc.epc_i; m_cnt++;
      end else if (!ifc.stall_i) begin
        if (ifc.jr_i) m_pc = ifc.jr_target_i;
        else if (ifc.jump_i) m_pc = ifc.jump_target_i;
        else if (ifc.br_taken_i) m_pc = ifc.d_pc_i + 4 + 32'(int'($signed(ifc.br_imm_i)) * 4);
        else m_pc = m_pc + 4;
        m_cnt++;
      end
      @(negedge clk);
      if (preload_req != preload_seen) begin
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1 release dut.fetch_cnt;
        m_cnt = 32'hFFFF_FFFF;
        preload_seen = preload_req;
      end
      exp_exc = (m_pc % 4 != 0) || m_pc < 32'h3000 || m_pc > 32'h6FFC;
      check("model pc", ifc.pc_o, m_pc);
      check("model cnt", ifc.fetch_cnt_o, m_cnt);
      check("model exc", 32'(ifc.if_exc_o), 32'(exp_exc));
      check("model exccode", 32'(ifc.if_exccode_o), exp_exc ? 32'd4 : 32'd0);
      check("model bd", 32'(ifc.if_bd_o), 32'(ifc.d_is_bj_i && !exp_exc));
    end
  end
  initial begin
    reset = 1;
    idle();
    ifc.epc_i = 0; ifc.d_pc_i = 0; ifc.br_imm_i = 0; ifc.jump_target_i = 0; ifc.jr_target_i = 0;
    cyc(); cyc();
    reset = 0;
    check("reset pc", ifc.pc_o, 32'h3000);
    check("reset cnt", ifc.fetch_cnt_o, 0);
    check("reset exc", 32'(ifc.if_exc_o), 0);
    cyc(); check("seq pc1", ifc.pc_o, 32'h3004);
    cyc(); check("seq pc2", ifc.pc_o, 32'h3008);
    cyc(); check("seq pc3", ifc.pc_o, 32'h300C);
    cyc(); check("seq cnt4", ifc.fetch_cnt_o, 4);
    ifc.d_pc_i = 32'h3010; ifc.br_taken_i = 1; ifc.br_imm_i = 16'hFFFC; ifc.d_is_bj_i = 1;
    #1 check("branch bd", 32'(ifc.if_bd_o), 1);
    cyc(); check("branch back pc", ifc.pc_o, 32'h3004);
    ifc.br_imm_i = 16'h0004;
    cyc(); check("branch fwd pc", ifc.pc_o, 32'h3024);
    idle();
    ifc.jump_i = 1; ifc.jump_target_i = 32'h3400; ifc.stall_i = 1;
    cyc(); check("stall pc", ifc.pc_o, 32'h3024); check("stall cnt", ifc.fetch_cnt_o, 6);
    ifc.stall_i = 0;
    cyc(); check("jump pc", ifc.pc_o, 32'h3400);
    idle();
    ifc.stall_i = 1; ifc.req_i = 1; ifc.eret_i = 1; ifc.epc_i = 32'h3104;
    cyc(); check("req wins pc", ifc.pc_o, 32'h4180); check("req cnt", ifc.fetch_cnt_o, 8);
    idle();
    ifc.eret_i = 1; ifc.jr_i = 1; ifc.jr_target_i = 32'h5000;
    cyc(); check("eret pc", ifc.pc_o, 32'h3104); check("eret cnt", ifc.fetch_cnt_o, 9);
    idle();
    ifc.jr_i = 1; ifc.jr_target_i = 32'h3002; ifc.d_is_bj_i = 1;
    cyc();
    check("adel unaligned exc", 32'(ifc.if_exc_o), 1);
    check("adel exccode", 32'(ifc.if_exccode_o), 4);
    check("adel bd", 32'(ifc.if_bd_o), 0);
    check("adel pc", ifc.pc_o, 32'h3002);
    ifc.jr_target_i = 32'h7000;
    cyc(); check("adel high exc", 32'(ifc.if_exc_o), 1);
    ifc.jr_target_i = 32'h6FFC;
    cyc(); check("limit exc", 32'(ifc.if_exc_o), 0);
    idle();
    preload_req++;
    @(negedge clk); #2;
    check("preload cnt", ifc.fetch_cnt_o, 32'hFFFF_FFFF);
    cyc(); check("wrap cnt", ifc.fetch_cnt_o, 0);
    for (int i = 0; i < 3000; i++) begin
      ifc.stall_i = $urandom_range(0, 3) == 0;
      ifc.req_i = $urandom_range(0, 31) == 0;
      ifc.eret_i = $urandom_range(0, 31) == 0;
      ifc.epc_i = 32'h3000 + 4 * $urandom_range(0, 4095);
      ifc.jr_i = $urandom_range(0, 9) == 0;
      ifc.jr_target_i = 32'h2FF0 + $urandom_range(0, 16'h4030);
      ifc.jump_i = $urandom_range(0, 9) == 0;
      ifc.jump_target_i = 32'h3000 + 4 * $urandom_range(0, 4095);
      ifc.br_taken_i = $urandom_range(0, 4) == 0;
      ifc.br_imm_i = 16'($urandom);
      ifc.d_pc_i = 32'h3000 + 4 * $urandom_range(0, 4095);
      ifc.d_is_bj_i = 1'($urandom);
      cyc();
    end
    idle();
    ifc.jump_i = 1; ifc.jump_target_i = 32'h3400; reset = 1;
    cyc(); check("midrun reset pc", ifc.pc_o, 32'h3000); check("midrun reset cnt", ifc.fetch_cnt_o, 0);
    reset = 0; idle();
    cyc(); check("post reset pc", ifc.pc_o, 32'h3004);
    @(negedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
